// File: rtl/program_loader.sv
// program_loader
//
// Boot-time loader that sits between a serial byte receiver and the
// instruction memory of the single-cycle core. It parses a framed image,
// assembles little-endian 32-bit words and writes them to memory. It holds
// the core in reset until the checksum of the whole image has been verified.
//
// Frame: N[7:0], N[15:8], N*4 payload bytes (LSB first per word), then one
// checksum byte equal to the XOR of all payload bytes.
//
// Ports
//   clock_i         system clock
//   reset_i         synchronous active-high reset
//   byte_valid_i    byte_data_i holds a byte
//   byte_data_i     stream byte
//   byte_ready_o    loader accepts a byte this cycle
//   imem_wr_en_o    one-cycle instruction memory write strobe
//   imem_wr_addr_o  byte address of the word being written
//   imem_wr_data_o  instruction word
//   core_reset_o    core reset; released only after a verified image
//   done_o          image verified, core running
//   error_o         load failed (sticky until reset_i)
//   words_loaded_o  words written so far
module program_loader #(
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_wr_en_o,
  output logic [31:0] imem_wr_addr_o,
  output logic [31:0] imem_wr_data_o,
  output logic        core_reset_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  // One bit wider than the header count so that MEM_WORDS = 65536 still
  // compares correctly.
  localparam logic [16:0] MAX_N = 17'(MEM_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [15:0] words_q, words_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        ready_q, ready_d;
  logic        core_rst_q, core_rst_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        accept;
  logic [15:0] n_hdr;

  // ready_q is a registered copy of "state is a loading state", so it is
  // the exact handshake qualifier for the current state.
  assign accept = byte_valid_i && ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    words_d    = words_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    n_hdr      = {byte_data_i, count_q[7:0]};

    if (accept) begin
      case (state_q)
        S_HDR_LO: begin
          count_d[7:0] = byte_data_i;
          state_d      = S_HDR_HI;
        end
        S_HDR_HI: begin
          count_d = n_hdr;
          if ({1'b0, n_hdr} > MAX_N) begin
            state_d = S_ERROR;
          end else if (n_hdr == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum_q ^ byte_data_i;
          if (byte_idx_q == 2'd3) begin
            // Top byte completes the word; the lower three are in word_q.
            wr_en_d    = 1'b1;
            wr_data_d  = {byte_data_i, word_q};
            wr_addr_d  = ADDR_BASE + {14'd0, words_q, 2'b00};
            words_d    = words_q + 16'd1;
            byte_idx_d = 2'd0;
            if ((words_q + 16'd1) == count_q) begin
              state_d = S_CHECK;
            end
          end else begin
            case (byte_idx_q)
              2'd0:    word_d[7:0]   = byte_data_i;
              2'd1:    word_d[15:8]  = byte_data_i;
              default: word_d[23:16] = byte_data_i;
            endcase
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
        S_CHECK: begin
          state_d = (byte_data_i == csum_q) ? S_RUN : S_ERROR;
        end
        default: begin
          // RUN and ERROR are terminal; ready_q is low there anyway.
        end
      endcase
    end

    // Status outputs are registered from the next state so they change in
    // the same cycle as the state itself.
    ready_d    = (state_d != S_RUN) && (state_d != S_ERROR);
    core_rst_d = (state_d != S_RUN);
    done_d     = (state_d == S_RUN);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_HDR_LO;
      count_q    <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      words_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      ready_q    <= 1'b1;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      words_q    <= words_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ready_q    <= ready_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign byte_ready_o   = ready_q;
  assign imem_wr_en_o   = wr_en_q;
  assign imem_wr_addr_o = wr_addr_q;
  assign imem_wr_data_o = wr_data_q;
  assign core_reset_o   = core_rst_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader. Two instances share the input stream: one with
// default parameters, one with a 4-word memory at base 0x100, so header
// limits and address offsets are both exercised by the same frames.
module tb_program_loader;

  localparam int          MW0 = 256;
  localparam int          MW1 = 4;
  localparam logic [31:0] BA0 = 32'h0000_0000;
  localparam logic [31:0] BA1 = 32'h0000_0100;

  logic        clk;
  logic        reset_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready[2];
  logic        wr_en[2];
  logic [31:0] wr_addr[2];
  logic [31:0] wr_data[2];
  logic        core_rst[2];
  logic        done[2];
  logic        err[2];
  logic [15:0] words[2];

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  frm[$];
  int          k;         // bytes offered with valid high since reset
  bit          acc_last;  // a byte was offered on the most recent edge

  program_loader u_dut0 (
    .clock_i(clk), .reset_i(reset_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready[0]), .imem_wr_en_o(wr_en[0]),
    .imem_wr_addr_o(wr_addr[0]), .imem_wr_data_o(wr_data[0]),
    .core_reset_o(core_rst[0]), .done_o(done[0]), .error_o(err[0]),
    .words_loaded_o(words[0])
  );

  program_loader #(.MEM_WORDS(MW1), .ADDR_BASE(BA1)) u_dut1 (
    .clock_i(clk), .reset_i(reset_i),
    .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
    .byte_ready_o(byte_ready[1]), .imem_wr_en_o(wr_en[1]),
    .imem_wr_addr_o(wr_addr[1]), .imem_wr_data_o(wr_data[1]),
    .core_reset_o(core_rst[1]), .done_o(done[1]), .error_o(err[1]),
    .words_loaded_o(words[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Payload word i of the current frame, little-endian.
  function automatic logic [31:0] frame_word(input int i);
    return {frm[2+4*i+3], frm[2+4*i+2], frm[2+4*i+1], frm[2+4*i]};
  endfunction

  // Reference: given how many bytes were offered since reset, derive the
  // loader status from the frame rules. st: 0 loading, 1 run, 2 error.
  function automatic void model(input int mwv, input int kv, input bit lastv,
                                output bit p, output int w, output int st);
    int n, kk, pay;
    logic [7:0] x;
    p = 0; w = 0; st = 0;
    if (kv < 2) return;
    n = {24'd0, frm[1], frm[0]};
    if (n > mwv) begin st = 2; return; end
    kk  = (kv > 3 + 4*n) ? 3 + 4*n : kv;  // bytes after the checksum are dropped
    pay = kk - 2;
    if (pay > 4*n) pay = 4*n;
    w = pay / 4;
    p = lastv && (kv > 2) && (kv <= 2 + 4*n) && ((kv - 2) % 4 == 0);
    if (kk == 3 + 4*n) begin
      x = 8'h00;
      for (int i = 0; i < 4*n; i++) x ^= frm[2+i];
      st = (frm[2+4*n] == x) ? 1 : 2;
    end
  endfunction

  task automatic check_all();
    bit p; int w, st; int mwv; logic [31:0] bav;
    for (int i = 0; i < 2; i++) begin
      mwv = (i == 0) ? MW0 : MW1;
      bav = (i == 0) ? BA0 : BA1;
      model(mwv, k, acc_last, p, w, st);
      chk($sformatf("d%0d.k%0d.wr_en", i, k), 32'(wr_en[i]), 32'(p));
      if (p) begin
        chk($sformatf("d%0d.k%0d.wr_addr", i, k), wr_addr[i], bav + 32'(4*(w-1)));
        chk($sformatf("d%0d.k%0d.wr_data", i, k), wr_data[i], frame_word(w-1));
      end
      chk($sformatf("d%0d.k%0d.words", i, k), 32'(words[i]), 32'(w));
      chk($sformatf("d%0d.k%0d.done", i, k), 32'(done[i]), 32'(st == 1));
      chk($sformatf("d%0d.k%0d.error", i, k), 32'(err[i]), 32'(st == 2));
      chk($sformatf("d%0d.k%0d.core_reset", i, k), 32'(core_rst[i]), 32'(st != 1));
      chk($sformatf("d%0d.k%0d.ready", i, k), 32'(byte_ready[i]), 32'(st == 0));
    end
  endtask

  // One clock: drive at the falling edge, sample at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d);
    byte_valid_i = v;
    byte_data_i  = d;
    @(posedge clk);
    if (v) k++;
    acc_last = v;
    @(negedge clk);
    byte_valid_i = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input bit v);
    reset_i      = 1'b1;
    byte_valid_i = v;
    byte_data_i  = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    reset_i      = 1'b0;
    byte_valid_i = 1'b0;
    k        = 0;
    acc_last = 0;
    check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.rst.wr_addr", i), wr_addr[i], 32'h0);
      chk($sformatf("d%0d.rst.wr_data", i), wr_data[i], 32'h0);
    end
  endtask

  // Offer bytes [first, last) of the frame with random idle gaps, then
  // extra bytes that should be ignored once the loader is terminal.
  task automatic send(input int first, input int last, input int gap_pct, input int extra);
    for (int i = first; i < last; i++) begin
      while ($urandom_range(99) < gap_pct) step(1'b0, 8'h00);
      step(1'b1, frm[i]);
    end
    for (int i = 0; i < extra; i++) step(1'b1, 8'($urandom));
  endtask

  task automatic build(input int n_hdr, input int n_words, input bit corrupt);
    logic [7:0] b, x;
    frm.delete();
    frm.push_back(n_hdr[7:0]);
    frm.push_back(n_hdr[15:8]);
    x = 8'h00;
    for (int i = 0; i < 4*n_words; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      x ^= b;
    end
    if (corrupt) x ^= 8'(1 << $urandom_range(7));
    frm.push_back(x);
  endtask

  initial begin
    reset_i      = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    k            = 0;
    acc_last     = 0;
    @(negedge clk);
    do_reset(1'b0);

    // Single word, reference bytes.
    frm = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC3};
    chk("ref.word0", frame_word(0), 32'h0050_0093);
    send(0, frm.size(), 0, 3);

    // Reset while running reasserts core reset.
    do_reset(1'b1);

    // Bad checksum: the write still happens, then error.
    frm = {8'h01, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    send(0, frm.size(), 0, 3);
    do_reset(1'b0);

    // Oversize header N=257.
    build(257, 0, 0);
    send(0, frm.size(), 0, 4);
    do_reset(1'b0);

    // Empty image.
    frm = {8'h00, 8'h00, 8'h00};
    send(0, frm.size(), 0, 2);
    do_reset(1'b0);

    // Three words with idle gaps.
    build(3, 3, 0);
    send(0, frm.size(), 40, 2);
    do_reset(1'b0);

    // Reset mid-load (with a byte offered on the reset cycle), then reload.
    for (int pre = 6; pre <= 7; pre++) begin
      build(2, 2, 0);
      send(0, 2 + pre, 0, 0);
      do_reset(1'b1);
      build(1, 1, 0);
      send(0, frm.size(), 20, 1);
      do_reset(1'b0);
    end

    // Header exactly at and just above the small instance's capacity.
    build(4, 4, 0);
    send(0, frm.size(), 20, 2);
    do_reset(1'b0);
    build(5, 5, 0);
    send(0, frm.size(), 20, 2);
    do_reset(1'b0);

    // Random frames, some corrupted.
    for (int t = 0; t < 8; t++) begin
      build($urandom_range(0, 6), 0, 0);
      build({16'd0, frm[1], frm[0]}, {16'd0, frm[1], frm[0]}, ($urandom_range(3) == 0));
      send(0, frm.size(), 30, $urandom_range(0, 3));
      do_reset($urandom_range(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
